// File: rtl/giro_controller.sv
// giro_controller: sequences the rotation actuator from a debounced keypad code.
// A valid key (1..9) with enable high starts a run of N revolutions on a
// 4-phase full-step stepper. One motor step happens every STEP_DIV clocks, and
// one revolution is STEPS_PER_REV steps. When the run finishes or is cancelled,
// done pulses for one cycle. The key must then be released before the next
// command is accepted.
//
// Ports:
//   clock_in             system clock
//   reset_in             asynchronous, active-high reset
//   numgiro_in[3:0]      keypad code; 0 = no key, 1..9 = revolutions
//   dir_in               direction (0 fwd, 1 rev), sampled at acceptance
//   enable_in            1 = accept/run, 0 while running = pause
//   cancel_in            abort the current run
//   fase_out[3:0]        one-hot coil phase, 0000 = coils off
//   busy_out             high while running and during the done cycle
//   done_out             one-cycle completion/abort pulse
//   giros_restantes_out  revolutions remaining
module giro_controller #(
  parameter int STEP_DIV      = 50000,
  parameter int STEPS_PER_REV = 2048
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [3:0] numgiro_in,
  input  logic       dir_in,
  input  logic       enable_in,
  input  logic       cancel_in,
  output logic [3:0] fase_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [3:0] giros_restantes_out
);

  localparam int TIMER_W = $clog2(STEP_DIV);
  localparam int STEP_W  = $clog2(STEPS_PER_REV);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS_PER_REV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    WAIT_RELEASE
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [STEP_W-1:0]  step_count;
  logic [1:0]         phase;
  logic               dir;

  logic               key_valid;
  logic [1:0]         next_phase;

  function automatic logic [3:0] phase_onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  assign key_valid  = (numgiro_in != 4'd0) && (numgiro_in <= 4'd9);
  // The phase index wraps mod 4 naturally in two bits.
  assign next_phase = dir ? (phase - 2'd1) : (phase + 2'd1);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state               <= IDLE;
      timer               <= '0;
      step_count          <= '0;
      phase               <= 2'd0;
      dir                 <= 1'b0;
      fase_out            <= 4'b0000;
      busy_out            <= 1'b0;
      done_out            <= 1'b0;
      giros_restantes_out <= 4'd0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_in && key_valid) begin
            state               <= RUN;
            dir                 <= dir_in;
            giros_restantes_out <= numgiro_in;
            timer               <= '0;
            step_count          <= '0;
            phase               <= 2'd0;
            fase_out            <= 4'b0001;
            busy_out            <= 1'b1;
          end
        end

        RUN: begin
          // Cancel wins over both a pause and a coincident step event.
          if (cancel_in) begin
            state    <= DONE;
            done_out <= 1'b1;
            fase_out <= 4'b0000;
          end else if (enable_in) begin
            if (timer == TIMER_LAST) begin
              timer <= '0;
              phase <= next_phase;
              if (step_count == STEP_LAST) begin
                step_count          <= '0;
                giros_restantes_out <= giros_restantes_out - 4'd1;
                // The last step of the last revolution de-energises directly.
                if (giros_restantes_out == 4'd1) begin
                  state    <= DONE;
                  done_out <= 1'b1;
                  fase_out <= 4'b0000;
                end else begin
                  fase_out <= phase_onehot(next_phase);
                end
              end else begin
                step_count <= step_count + 1'b1;
                fase_out   <= phase_onehot(next_phase);
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        DONE: begin
          state    <= WAIT_RELEASE;
          busy_out <= 1'b0;
          fase_out <= 4'b0000;
        end

        WAIT_RELEASE: begin
          // A key still held from the previous command must not retrigger.
          if (numgiro_in == 4'd0) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          fase_out <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_giro_controller.sv
// Testbench for giro_controller with STEP_DIV=4, STEPS_PER_REV=8.
// A table of {inputs, cycles, expected outputs} records, hand-written
// sequences for the multi-cycle timing cases, and a randomized phase. Every
// clock is also compared against a reference model. The model tracks a run as
// a count of active RUN cycles and derives the phase and the revolutions left
// from that count arithmetically.
module tb_giro_controller;

  localparam int SD      = 4;
  localparam int SPR     = 8;
  localparam int REV_CYC = SD * SPR;

  logic       clock_in   = 1'b0;
  logic       reset_in   = 1'b1;
  logic [3:0] numgiro_in = 4'd0;
  logic       dir_in     = 1'b0;
  logic       enable_in  = 1'b0;
  logic       cancel_in  = 1'b0;
  logic [3:0] fase_out;
  logic       busy_out;
  logic       done_out;
  logic [3:0] giros_restantes_out;

  giro_controller #(
    .STEP_DIV      (SD),
    .STEPS_PER_REV (SPR)
  ) dut (
    .clock_in            (clock_in),
    .reset_in            (reset_in),
    .numgiro_in          (numgiro_in),
    .dir_in              (dir_in),
    .enable_in           (enable_in),
    .cancel_in           (cancel_in),
    .fase_out            (fase_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .giros_restantes_out (giros_restantes_out)
  );

  always #5 clock_in = ~clock_in;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 run, 2 done, 3 wait for release.
  int m_mode = 0;
  int m_n    = 0;
  int m_dir  = 0;
  int m_k    = 0;
  int m_rem  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_n    = 0;
    m_dir  = 0;
    m_k    = 0;
    m_rem  = 0;
  endtask

  task automatic model_edge();
    int num;
    num = int'(numgiro_in);
    case (m_mode)
      0: if (enable_in && num >= 1 && num <= 9) begin
           m_mode = 1;
           m_n    = num;
           m_dir  = int'(dir_in);
           m_k    = 0;
           m_rem  = num;
         end
      1: if (cancel_in) begin
           m_mode = 2;
         end else if (enable_in) begin
           m_k++;
           m_rem = m_n - m_k / REV_CYC;
           if (m_k == m_n * REV_CYC) m_mode = 2;
         end
      2: m_mode = 3;
      default: if (num == 0) m_mode = 0;
    endcase
  endtask

  function automatic int model_word();
    logic [3:0] f;
    logic       b;
    logic       d;
    int         s;
    int         ph;
    f = 4'b0000;
    b = 1'b0;
    d = 1'b0;
    case (m_mode)
      1: begin
        s  = m_k / SD;
        ph = (m_dir != 0) ? (4 - (s % 4)) % 4 : s % 4;
        f  = 4'(1 << ph);
        b  = 1'b1;
      end
      2: begin
        b = 1'b1;
        d = 1'b1;
      end
      default: ;
    endcase
    return int'({f, b, d, 4'(m_rem)});
  endfunction

  function automatic int dut_word();
    return int'({fase_out, busy_out, done_out, giros_restantes_out});
  endfunction

  task automatic tick();
    @(posedge clock_in);
    if (!reset_in) model_edge();
    #1;
    check("model", dut_word(), model_word());
  endtask

  task automatic run_until_done(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      cycles++;
      if (done_out) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0] num;
    logic       dir;
    logic       en;
    logic       cancel;
    int         cycles;
    logic [3:0] fase;
    logic       busy;
    logic       done;
    logic [3:0] rem;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int  c;
    int  c2;
    int  t_rem1;
    bit  fin;
    int  r;
    logic [3:0] saved;
    logic [3:0] seq[5];

    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;

    //          num    dir   en    can  cyc  fase     busy  done  rem
    tbl[0]  = '{4'd12, 1'b0, 1'b1, 1'b0, 2, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{4'd0,  1'b0, 1'b1, 1'b0, 2, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{4'd5,  1'b0, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{4'd1,  1'b1, 1'b1, 1'b0, 1, 4'b0001, 1'b1, 1'b0, 4'd1};
    tbl[4]  = '{4'd0,  1'b0, 1'b1, 1'b0, 4, 4'b1000, 1'b1, 1'b0, 4'd1};
    tbl[5]  = '{4'd0,  1'b0, 1'b1, 1'b0, 4, 4'b0100, 1'b1, 1'b0, 4'd1};
    tbl[6]  = '{4'd0,  1'b0, 1'b1, 1'b0, 4, 4'b0010, 1'b1, 1'b0, 4'd1};
    tbl[7]  = '{4'd0,  1'b0, 1'b1, 1'b0, 4, 4'b0001, 1'b1, 1'b0, 4'd1};
    tbl[8]  = '{4'd0,  1'b0, 1'b1, 1'b0, 15, 4'b0010, 1'b1, 1'b0, 4'd1};
    tbl[9]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b1, 1'b1, 4'd0};
    tbl[10] = '{4'd2,  1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[11] = '{4'd2,  1'b0, 1'b1, 1'b0, 3, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[12] = '{4'd0,  1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b0, 1'b0, 4'd0};
    tbl[13] = '{4'd2,  1'b0, 1'b1, 1'b0, 1, 4'b0001, 1'b1, 1'b0, 4'd2};
    tbl[14] = '{4'd0,  1'b0, 1'b1, 1'b0, 6, 4'b0010, 1'b1, 1'b0, 4'd2};
    tbl[15] = '{4'd0,  1'b0, 1'b0, 1'b0, 10, 4'b0010, 1'b1, 1'b0, 4'd2};
    tbl[16] = '{4'd0,  1'b0, 1'b1, 1'b0, 2, 4'b0100, 1'b1, 1'b0, 4'd2};
    tbl[17] = '{4'd0,  1'b0, 1'b0, 1'b1, 1, 4'b0000, 1'b1, 1'b1, 4'd2};
    tbl[18] = '{4'd0,  1'b0, 1'b1, 1'b0, 1, 4'b0000, 1'b0, 1'b0, 4'd2};
    tbl[19] = '{4'd0,  1'b0, 1'b1, 1'b1, 1, 4'b0000, 1'b0, 1'b0, 4'd2};

    // Reset state
    model_reset();
    repeat (2) @(posedge clock_in);
    #1;
    check("reset_fase", int'(fase_out), 0);
    check("reset_busy", int'(busy_out), 0);
    check("reset_done", int'(done_out), 0);
    check("reset_rem", int'(giros_restantes_out), 0);
    reset_in = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      numgiro_in = tbl[i].num;
      dir_in     = tbl[i].dir;
      enable_in  = tbl[i].en;
      cancel_in  = tbl[i].cancel;
      repeat (tbl[i].cycles) tick();
      check($sformatf("table%0d", i), dut_word(),
            int'({tbl[i].fase, tbl[i].busy, tbl[i].done, tbl[i].rem}));
    end
    cancel_in = 1'b0;

    // Forward two-revolution run, key held throughout
    numgiro_in = 4'd2;
    dir_in     = 1'b0;
    enable_in  = 1'b1;
    tick();
    check("busy_rise", int'(busy_out), 1);
    check("first_phase", int'(fase_out), 1);
    c      = 0;
    t_rem1 = -1;
    fin    = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      tick();
      c++;
      if (c % 4 == 0 && c <= 16) check("fwd_seq", int'(fase_out), int'(seq[c / 4]));
      if (t_rem1 < 0 && giros_restantes_out == 4'd1) t_rem1 = c;
      if (done_out) fin = 1'b1;
    end
    check("run2_done_seen", int'(fin), 1);
    check("rem_2to1_cycles", t_rem1, 32);
    check("run2_cycles", c, 64);
    tick();
    check("done_once", int'(done_out), 0);
    check("coils_off_after_done", int'(fase_out), 0);

    // Held key must not restart; release and issue 3
    repeat (5) tick();
    check("held_key_no_restart", int'(busy_out), 0);
    numgiro_in = 4'd0;
    tick();
    numgiro_in = 4'd3;
    tick();
    check("rem3_on_accept", int'(giros_restantes_out), 3);
    numgiro_in = 4'd0;
    run_until_done(c, fin);
    check("run3_done_seen", int'(fin), 1);
    check("run3_cycles", c, 96);

    // Pause for 10 cycles mid-run
    tick();
    tick();
    numgiro_in = 4'd3;
    tick();
    numgiro_in = 4'd0;
    repeat (40) tick();
    saved     = fase_out;
    enable_in = 1'b0;
    repeat (10) tick();
    check("pause_fase_held", int'(fase_out), int'(saved));
    check("pause_busy", int'(busy_out), 1);
    enable_in = 1'b1;
    run_until_done(c2, fin);
    check("pause_done_seen", int'(fin), 1);
    check("pause_total_cycles", 50 + c2, 106);

    // Cancel in the second revolution
    tick();
    tick();
    numgiro_in = 4'd3;
    tick();
    numgiro_in = 4'd0;
    repeat (40) tick();
    cancel_in = 1'b1;
    tick();
    cancel_in = 1'b0;
    check("cancel_done", int'(done_out), 1);
    check("cancel_rem", int'(giros_restantes_out), 2);
    check("cancel_coils", int'(fase_out), 0);
    check("cancel_busy", int'(busy_out), 1);
    tick();
    check("cancel_after_done", int'(done_out), 0);
    check("cancel_after_busy", int'(busy_out), 0);

    // Asynchronous reset in the middle of a run
    tick();
    numgiro_in = 4'd1;
    tick();
    numgiro_in = 4'd0;
    repeat (6) tick();
    #2;
    reset_in = 1'b1;
    #1;
    check("reset_async_fase", int'(fase_out), 0);
    check("reset_async_busy", int'(busy_out), 0);
    model_reset();
    @(posedge clock_in);
    #1;
    reset_in = 1'b0;
    tick();
    check("idle_after_reset", int'(busy_out), 0);
    numgiro_in = 4'd1;
    tick();
    check("accept_after_reset", int'(busy_out), 1);
    numgiro_in = 4'd0;

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      numgiro_in = 4'd0;
        else if (r < 8) numgiro_in = 4'($urandom_range(1, 3));
        else            numgiro_in = 4'($urandom_range(10, 15));
      end
      dir_in    = 1'($urandom_range(0, 1));
      enable_in = ($urandom_range(0, 9) != 0);
      cancel_in = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
